// File: rtl/alu_ops_pkg.sv
// rtl/alu_ops_pkg.sv - ALU op-code encodings, FSM states and shared constants
package alu_ops_pkg;

    // Shared with the ALU control decoder so the encodings cannot drift apart.
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_NOR     = 4'b0010;
    localparam logic [3:0] ALU_ADD     = 4'b0011;
    localparam logic [3:0] ALU_SUB     = 4'b0100;
    localparam logic [3:0] ALU_SRL     = 4'b0101;
    localparam logic [3:0] ALU_SLL     = 4'b0110;
    localparam logic [3:0] ALU_MUL     = 4'b0111;
    localparam logic [3:0] ALU_DEFAULT = 4'b1001;

    localparam int ILLEGAL_OP_RESULT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_MULT  = 2'd3
    } alu_state_t;

endpackage

// File: rtl/alu_shift_step.sv
// rtl/alu_shift_step.sv - combinational shift by 0..SHIFT_STEP bits, zero fill
module alu_shift_step #(
    parameter int DATA_WIDTH = 32,
    parameter int AMT_WIDTH  = 1
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [AMT_WIDTH-1:0]  amt,
    input  logic                  left,
    output logic [DATA_WIDTH-1:0] result
);

    assign result = left ? (data << amt) : (data >> amt);

endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - execute-stage ALU, iterative shifts; MUL when ALU_MULT_EN is defined
module multicycle_alu
    import alu_ops_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5,
    parameter int SHIFT_STEP  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             ALUOperation,
    input  logic [DATA_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]  B,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  ALUResult,
    output logic                   Zero,
    output logic                   IllegalOp
);

    localparam int AMT_WIDTH = $clog2(SHIFT_STEP + 1);

    alu_state_t             state, state_n;
    logic [3:0]             op_q;
    logic [DATA_WIDTH-1:0]  work;
    logic [SHAMT_WIDTH-1:0] rem, rem_n;
    logic [AMT_WIDTH-1:0]   step_amt;
    logic [DATA_WIDTH-1:0]  shift_out;

    logic                   fin;
    logic                   fin_illegal;
    logic [DATA_WIDTH-1:0]  fin_result;
    logic                   load_shift;

`ifdef ALU_MULT_EN
    logic [DATA_WIDTH-1:0]  mult_acc, mult_mcand, mult_mplier, mult_sum;
    logic                   load_mult;

    assign mult_sum = mult_acc + (mult_mplier[0] ? mult_mcand : '0);
`endif

    // The final step of a shift may be shorter than SHIFT_STEP.
    assign step_amt = (rem < SHAMT_WIDTH'(SHIFT_STEP)) ? rem[AMT_WIDTH-1:0]
                                                       : AMT_WIDTH'(SHIFT_STEP);
    assign rem_n    = rem - SHAMT_WIDTH'(step_amt);

    alu_shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .AMT_WIDTH  (AMT_WIDTH)
    ) u_shift_step (
        .data   (work),
        .amt    (step_amt),
        .left   (op_q == ALU_SLL),
        .result (shift_out)
    );

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_n     = state;
        fin         = 1'b0;
        fin_illegal = 1'b0;
        fin_result  = '0;
        load_shift  = 1'b0;
`ifdef ALU_MULT_EN
        load_mult   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (ALUOperation)
                        ALU_AND: begin fin = 1'b1; fin_result = A & B;    end
                        ALU_OR:  begin fin = 1'b1; fin_result = A | B;    end
                        ALU_NOR: begin fin = 1'b1; fin_result = ~(A | B); end
                        ALU_ADD: begin fin = 1'b1; fin_result = A + B;    end
                        ALU_SUB: begin fin = 1'b1; fin_result = A + ~B + DATA_WIDTH'(1); end
                        ALU_SRL, ALU_SLL: begin
                            if (shamt == '0) begin
                                fin        = 1'b1;
                                fin_result = B;
                            end else begin
                                load_shift = 1'b1;
                                state_n    = ST_SHIFT;
                            end
                        end
`ifdef ALU_MULT_EN
                        ALU_MUL: begin
                            load_mult = 1'b1;
                            state_n   = ST_MULT;
                        end
`endif
                        default: begin
                            fin         = 1'b1;
                            fin_illegal = 1'b1;
                            fin_result  = DATA_WIDTH'(ILLEGAL_OP_RESULT);
                        end
                    endcase
                    if (fin) state_n = ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (rem_n == '0) begin
                    fin        = 1'b1;
                    fin_result = shift_out;
                    state_n    = ST_DONE;
                end
            end
`ifdef ALU_MULT_EN
            // Always runs all DATA_WIDTH multiplier bits; no early exit.
            ST_MULT: begin
                if (rem == '0) begin
                    fin        = 1'b1;
                    fin_result = mult_sum;
                    state_n    = ST_DONE;
                end
            end
`endif
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            done        <= 1'b0;
            ALUResult   <= '0;
            Zero        <= 1'b1;
            IllegalOp   <= 1'b0;
            op_q        <= ALU_AND;
            work        <= '0;
            rem         <= '0;
`ifdef ALU_MULT_EN
            mult_acc    <= '0;
            mult_mcand  <= '0;
            mult_mplier <= '0;
`endif
        end else begin
            state <= state_n;
            done  <= fin;
            if (fin) begin
                ALUResult <= fin_result;
                Zero      <= (fin_result == '0);
                IllegalOp <= fin_illegal;
            end
            if (state == ST_IDLE && start) op_q <= ALUOperation;
            if (load_shift) begin
                work <= B;
                rem  <= shamt;
            end else if (state == ST_SHIFT) begin
                work <= shift_out;
                rem  <= rem_n;
            end
`ifdef ALU_MULT_EN
            else if (load_mult) begin
                mult_acc    <= '0;
                mult_mcand  <= A;
                mult_mplier <= B;
                rem         <= SHAMT_WIDTH'(DATA_WIDTH - 1);
            end else if (state == ST_MULT) begin
                mult_acc    <= mult_sum;
                mult_mcand  <= mult_mcand << 1;
                mult_mplier <= mult_mplier >> 1;
                rem         <= rem - SHAMT_WIDTH'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - self-checking bench for multicycle_alu against a behavioural model
module tb_multicycle_alu;
    import alu_ops_pkg::*;

    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  ALUOperation;
    logic [31:0] A, B, ALUResult;
    logic [4:0]  shamt;
    logic        busy, done, Zero, IllegalOp;

    int checks = 0;
    int failures = 0;

    logic [31:0] r_res;
    logic        r_zero, r_ill;
    int          r_lat;
    bit          r_busy_ok;

    multicycle_alu #(.DATA_WIDTH(32), .SHAMT_WIDTH(5), .SHIFT_STEP(STEP)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUOperation(ALUOperation),
        .A(A), .B(B), .shamt(shamt), .busy(busy), .done(done),
        .ALUResult(ALUResult), .Zero(Zero), .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, output logic [31:0] r, output logic ill,
                                  output int lat);
        ill = 1'b0;
        lat = 1;
        case (op)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_NOR: r = ~(a | b);
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_SRL: begin r = b >> sh; lat = 1 + (int'(sh) + STEP - 1) / STEP; end
            ALU_SLL: begin r = b << sh; lat = 1 + (int'(sh) + STEP - 1) / STEP; end
`ifdef ALU_MULT_EN
            ALU_MUL: begin r = a * b; lat = 33; end
`endif
            default: begin r = 32'h0; ill = 1'b1; end
        endcase
    endfunction

    // Launch one op and wait for done; inputs are scrambled after launch.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input bit noise);
        @(negedge clk);
        ALUOperation = op; A = a; B = b; shamt = sh; start = 1'b1;
        @(negedge clk);
        r_lat = 1;
        r_busy_ok = 1'b1;
        start = 1'b0;
        A = $urandom; B = $urandom; shamt = 5'($urandom); ALUOperation = 4'($urandom);
        while (done !== 1'b1 && r_lat < 200) begin
            if (busy !== 1'b1) r_busy_ok = 1'b0;
            if (noise) start = 1'($urandom);
            @(negedge clk);
            r_lat++;
        end
        start = 1'b0;
        if (busy !== 1'b1) r_busy_ok = 1'b0;
        r_res = ALUResult; r_zero = Zero; r_ill = IllegalOp;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (ALUResult !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", ALUResult); end
        checks++; if (Zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", Zero); end
        checks++; if (IllegalOp !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", IllegalOp); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy=%b done=%b exp=0,0", busy, done); end
    endtask

    task automatic test_add;
        run_op(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0);
        checks++; if (r_lat !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", r_lat); end
        checks++; if (r_res !== 32'h0) begin failures++; $display("FAIL add_result got=%h exp=0", r_res); end
        checks++; if (r_zero !== 1'b1 || r_ill !== 1'b0) begin failures++; $display("FAIL add_flags zero=%b ill=%b exp=1,0", r_zero, r_ill); end
    endtask

    task automatic test_back_to_back;
        run_op(ALU_SUB, 32'd5, 32'd7, 5'd0, 1'b0);
        checks++; if (r_res !== 32'hFFFF_FFFE || r_lat !== 1) begin failures++; $display("FAIL sub_result got=%h lat=%0d exp=fffffffe lat=1", r_res, r_lat); end
        ALUOperation = ALU_NOR; A = 32'h0; B = 32'h0; start = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL start_in_done_ignored done=%b busy=%b exp=0,0", done, busy); end
        checks++; if (ALUResult !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub_result_held got=%h exp=fffffffe", ALUResult); end
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b1 || ALUResult !== 32'hFFFF_FFFF || Zero !== 1'b0) begin
            failures++; $display("FAIL nor_reissued done=%b got=%h zero=%b exp=1 ffffffff 0", done, ALUResult, Zero);
        end
    endtask

    task automatic test_shift;
        run_op(ALU_SLL, 32'h1, 32'h1, 5'd31, 1'b0);
        checks++; if (r_lat !== 32) begin failures++; $display("FAIL sll31_latency got=%0d exp=32", r_lat); end
        checks++; if (r_res !== 32'h8000_0000) begin failures++; $display("FAIL sll31_result got=%h exp=80000000", r_res); end
        checks++; if (!r_busy_ok) begin failures++; $display("FAIL sll31_busy got=dropped exp=held"); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || ALUResult !== 32'h8000_0000) begin
            failures++; $display("FAIL done_one_cycle done=%b busy=%b res=%h exp=0 0 80000000", done, busy, ALUResult);
        end
        run_op(ALU_SRL, 32'h0, 32'h8000_0000, 5'd4, 1'b0);
        checks++; if (r_lat !== 5 || r_res !== 32'h0800_0000 || !r_busy_ok) begin
            failures++; $display("FAIL srl4 got=%h lat=%0d busy_ok=%b exp=08000000 lat=5 1", r_res, r_lat, r_busy_ok);
        end
        run_op(ALU_SRL, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b0);
        checks++; if (r_lat !== 1 || r_res !== 32'hDEAD_BEEF) begin failures++; $display("FAIL shamt0 got=%h lat=%0d exp=deadbeef lat=1", r_res, r_lat); end
    endtask

    task automatic test_illegal;
        logic [31:0] b, er;
        logic        ei;
        int          el;
        run_op(ALU_DEFAULT, 32'h1234, 32'h1234, 5'd0, 1'b0);
        checks++; if (r_lat !== 1 || r_res !== 32'h0 || r_ill !== 1'b1 || r_zero !== 1'b1) begin
            failures++; $display("FAIL illegal_1001 got=%h ill=%b zero=%b lat=%0d exp=0 1 1 1", r_res, r_ill, r_zero, r_lat);
        end
        b = $urandom | 32'h1;
        model(ALU_SLL, 32'h0, b, 5'd25, er, ei, el);
        run_op(ALU_SLL, 32'h0, b, 5'd25, 1'b1);
        checks++; if (r_lat !== el || r_res !== er || r_ill !== ei) begin
            failures++; $display("FAIL start_while_busy got=%h lat=%0d ill=%b exp=%h lat=%0d ill=%b", r_res, r_lat, r_ill, er, el, ei);
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        @(negedge clk);
        ALUOperation = ALU_SLL; A = 32'h0; B = 32'h0000_0001; shamt = 5'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b1) begin
            failures++; $display("FAIL reset_mid busy=%b done=%b res=%h zero=%b exp=0 0 0 1", busy, done, ALUResult, Zero);
        end
        reset = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL reset_mid_no_done got=%0d pulses exp=0", seen); end
        run_op(ALU_ADD, 32'd2, 32'd3, 5'd0, 1'b0);
        checks++; if (r_res !== 32'd5 || r_lat !== 1) begin failures++; $display("FAIL add_after_reset got=%h lat=%0d exp=5 lat=1", r_res, r_lat); end
    endtask

    task automatic test_mult;
        run_op(ALU_MUL, 32'h0001_0001, 32'h0001_0001, 5'd0, 1'b0);
`ifdef ALU_MULT_EN
        checks++; if (r_lat !== 33 || r_res !== 32'h0002_0001 || r_ill !== 1'b0) begin
            failures++; $display("FAIL mul got=%h lat=%0d ill=%b exp=00020001 lat=33 ill=0", r_res, r_lat, r_ill);
        end
`else
        checks++; if (r_lat !== 1 || r_ill !== 1'b1 || r_res !== 32'h0) begin
            failures++; $display("FAIL op0111_illegal got=%h lat=%0d ill=%b exp=0 lat=1 ill=1", r_res, r_lat, r_ill);
        end
`endif
    endtask

    task automatic test_random;
        logic [3:0]  op;
        logic [31:0] a, b, er;
        logic [4:0]  sh;
        logic        ei;
        int          el;
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 7)) : 4'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            sh = 5'($urandom);
            model(op, a, b, sh, er, ei, el);
            run_op(op, a, b, sh, 1'($urandom));
            checks++; if (r_res !== er || r_zero !== (er == 32'h0) || r_ill !== ei || r_lat !== el) begin
                failures++;
                $display("FAIL random_%0d op=%b got=%h z=%b ill=%b lat=%0d exp=%h z=%b ill=%b lat=%0d",
                         i, op, r_res, r_zero, r_ill, r_lat, er, (er == 32'h0), ei, el);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; ALUOperation = 4'h0; A = 32'h0; B = 32'h0; shamt = 5'd0;
        repeat (3) @(negedge clk);
        test_reset;
        test_add;
        test_back_to_back;
        test_shift;
        test_illegal;
        test_reset_mid;
        test_mult;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
